// File: rtl/time_manager_pkg.sv
// Shared types and constants for the emulation time-base arbiter.
// Optional breakpoint support is enabled with TIME_MGR_BREAK_EN.
package time_mgr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int TIME_WIDTH_DEF = 32;

endpackage

// File: rtl/time_manager_if.sv
// Bundle between the emulator harness and the time manager.
// Breakpoint signals exist only when TIME_MGR_BREAK_EN is defined.
interface time_manager_if
    import time_mgr_pkg::*;
#(
    parameter int N_CLOCKS   = 4,
    parameter int TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int CNT_WIDTH  = 32
);

    logic [N_CLOCKS*TIME_WIDTH-1:0] time_clock_flat;
    logic                           run;
    logic                           step;
    logic [TIME_WIDTH-1:0]          time_next;
    state_t                         state;
    logic [CNT_WIDTH-1:0]           adv_count;
    logic                           time_sat;
    logic                           err_mono;
`ifdef TIME_MGR_BREAK_EN
    logic [TIME_WIDTH-1:0]          break_time;
    logic                           break_hit;
`endif

    modport master (
        output time_clock_flat, run, step,
        input  time_next, state, adv_count,
        input  time_sat, err_mono
`ifdef TIME_MGR_BREAK_EN
        , output break_time
        , input  break_hit
`endif
    );

    modport slave (
        input  time_clock_flat, run, step,
        output time_next, state, adv_count,
        output time_sat, err_mono
`ifdef TIME_MGR_BREAK_EN
        , input  break_time
        , output break_hit
`endif
    );

endinterface

// File: rtl/time_manager_min_tree.sv
// Balanced binary minimum over N unsigned W-bit words.
// Leaves beyond N are padded with all-ones so they never win.
module min_tree #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N*W-1:0] in_i,
    output logic [W-1:0]   min_o
);

    localparam int LV = (N > 1) ? $clog2(N) : 0;
    localparam int P  = 1 << LV;

    function automatic logic [W-1:0] reduce(
        input logic [N*W-1:0] flat
    );
        logic [W-1:0] node [1:2*P-1];
        for (int i = 0; i < P; i++) begin
            if (i < N) node[P+i] = flat[i*W +: W];
            else       node[P+i] = '1;
        end
        for (int k = P - 1; k >= 1; k--) begin
            node[k] = (node[2*k+1] < node[2*k])
                    ? node[2*k+1] : node[2*k];
        end
        return node[1];
    endfunction

    assign min_o = reduce(in_i);

endmodule

// File: rtl/time_manager.sv
// Reduces clock schedules to a global minimum, gated by run/halt/step.
// Define TIME_MGR_BREAK_EN to add a time breakpoint.
module time_manager
    import time_mgr_pkg::*;
#(
    parameter int N_CLOCKS   = 4,
    parameter int TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int CNT_WIDTH  = 32
) (
    input logic           clk_sys,
    input logic           rst_n,
    time_manager_if.slave bus
);

    localparam logic [TIME_WIDTH-1:0] T_MAX = '1;

    logic [TIME_WIDTH-1:0] min_c;
    logic [TIME_WIDTH-1:0] time_next_q, time_next_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic                  sat_q, sat_d;
    logic                  mono_q, mono_d;
    logic                  adv;
    logic                  at_max;
    logic                  brk;
    logic                  resume;

    min_tree #(
        .N (N_CLOCKS),
        .W (TIME_WIDTH)
    ) u_min (
        .in_i  (bus.time_clock_flat),
        .min_o (min_c)
    );

    assign at_max = (min_c == T_MAX);

`ifdef TIME_MGR_BREAK_EN
    logic brk_hit_q, brk_hit_d;
    logic resume_q;

    // The first RUN cycle after a resume steps past the breakpoint.
    assign brk = (min_c > bus.break_time) && !resume_q;
    assign brk_hit_d = resume ? 1'b0
                     : (brk_hit_q | ((state_q == RUN) & brk));
    assign bus.break_hit = brk_hit_q;

    // Breakpoint flag and resume marker.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            brk_hit_q <= 1'b0;
            resume_q  <= 1'b0;
        end else begin
            brk_hit_q <= brk_hit_d;
            resume_q  <= resume;
        end
    end
`else
    assign brk = 1'b0;
`endif

    // Run/halt/step control; saturation forces HALT on any advance.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: if (bus.run) state_d = RUN;
            RUN: begin
                if (brk || !bus.run) state_d = HALT;
                else                 adv     = 1'b1;
            end
            HALT: begin
                if (!sat_q) begin
                    adv = bus.step;
                    if (bus.run) state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv && at_max) state_d = HALT;
    end

    assign resume      = (state_q == HALT) && (state_d == RUN);
    assign time_next_d = adv ? min_c : time_next_q;
    assign cnt_d       = adv ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    assign sat_d       = sat_q | (adv & at_max);
    assign mono_d      = mono_q | (adv & (min_c < time_next_q));

    // Architectural state.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            time_next_q <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            mono_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_next_q <= time_next_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            mono_q      <= mono_d;
        end
    end

    assign bus.time_next = time_next_q;
    assign bus.state     = state_q;
    assign bus.adv_count = cnt_q;
    assign bus.time_sat  = sat_q;
    assign bus.err_mono  = mono_q;

endmodule

// File: tb/tb_time_manager.sv
// Self-checking bench for time_manager: directed table plus random
// run against a reference model. Honors TIME_MGR_BREAK_EN.
module tb_time_manager;
    import time_mgr_pkg::*;

    localparam int N  = 4;
    localparam int TW = 32;
    localparam int CW = 32;
    localparam logic [TW-1:0] TMAX = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    time_manager_if #(
        .N_CLOCKS(N), .TIME_WIDTH(TW), .CNT_WIDTH(CW)
    ) bus ();

    time_manager #(
        .N_CLOCKS(N), .TIME_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    logic [TW-1:0] ct [N];

    logic [TW-1:0] m_tn;
    logic [CW-1:0] m_cnt;
    int            m_st;
    bit            m_sat, m_mono, m_bh, m_res;

    typedef struct {
        logic [TW-1:0] a, b, c, d;
        bit            run, step;
        logic [TW-1:0] tn;
        int            st;
        logic [CW-1:0] cnt;
        bit            sat, mono;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_all(input string tag,
                           input logic [TW-1:0] tn, input int st,
                           input logic [CW-1:0] cnt,
                           input bit sat, input bit mono);
        chk({tag, ".time_next"}, 64'(bus.time_next), 64'(tn));
        chk({tag, ".state"}, 64'(bus.state), 64'(st));
        chk({tag, ".adv_count"}, 64'(bus.adv_count), 64'(cnt));
        chk({tag, ".time_sat"}, 64'(bus.time_sat), 64'(sat));
        chk({tag, ".err_mono"}, 64'(bus.err_mono), 64'(mono));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++)
            bus.time_clock_flat[i*TW +: TW] = ct[i];
    endtask

    task automatic model_reset();
        m_tn = '0; m_cnt = '0; m_st = 0;
        m_sat = 0; m_mono = 0; m_bh = 0; m_res = 0;
    endtask

    // Spec-level model of one clk_sys edge.
    task automatic model_edge();
        logic [TW-1:0] mn;
        int  nst;
        bit  go;
        mn  = ct[0];
        for (int i = 1; i < N; i++) if (ct[i] < mn) mn = ct[i];
        nst = m_st;
        go  = 0;
        if (m_st == 0) begin
            if (bus.run) nst = 1;
        end else if (m_st == 1) begin
            bit hit;
            hit = 0;
`ifdef TIME_MGR_BREAK_EN
            hit = (mn > bus.break_time) && !m_res;
`endif
            if (hit) begin nst = 2; m_bh = 1; end
            else if (!bus.run) nst = 2;
            else go = 1;
        end else begin
            if (!m_sat) begin
                go = bus.step;
                if (bus.run) nst = 1;
            end
        end
        if (go) begin
            if (mn < m_tn) m_mono = 1;
            m_tn  = mn;
            m_cnt = m_cnt + 1;
            if (mn == TMAX) begin m_sat = 1; nst = 2; end
        end
        m_res = (m_st == 2) && (nst == 1);
        if (m_res) m_bh = 0;
        m_st = nst;
    endtask

    task automatic tick();
        drive();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.run  = 1'b0;
        bus.step = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(
        input logic [TW-1:0] a, b, c, d,
        input bit run, step,
        input logic [TW-1:0] tn, input int st,
        input logic [CW-1:0] cnt, input bit sat, mono);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.d = d;
        v.run = run; v.step = step;
        v.tn = tn; v.st = st; v.cnt = cnt;
        v.sat = sat; v.mono = mono;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) ct[i] = '0;
        drive();
        bus.run  = 1'b0;
        bus.step = 1'b0;
`ifdef TIME_MGR_BREAK_EN
        bus.break_time = TMAX;
`endif

        vt.push_back(mk(10, 25, 40, 60, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(10, 25, 40, 60, 1, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(10, 25, 40, 60, 1, 0, 10, 1, 1, 0, 0));
        vt.push_back(mk(30, 25, 40, 60, 1, 0, 25, 1, 2, 0, 0));
        vt.push_back(mk(30, 35, 40, 60, 0, 1, 25, 2, 2, 0, 0));
        vt.push_back(mk(30, 35, 40, 60, 0, 0, 25, 2, 2, 0, 0));
        vt.push_back(mk(30, 35, 40, 60, 0, 1, 30, 2, 3, 0, 0));
        vt.push_back(mk(45, 35, 40, 60, 0, 0, 30, 2, 3, 0, 0));
        vt.push_back(mk(45, 35, 40, 60, 0, 1, 35, 2, 4, 0, 0));
        vt.push_back(mk(50, 55, 60, 70, 1, 1, 50, 1, 5, 0, 0));
        vt.push_back(mk(60, 55, 70, 80, 1, 0, 55, 1, 6, 0, 0));
        vt.push_back(mk(20, 55, 70, 80, 1, 0, 20, 1, 7, 0, 1));
        vt.push_back(mk(TMAX, TMAX, TMAX, TMAX, 1, 0,
                        TMAX, 2, 8, 1, 1));
        vt.push_back(mk(TMAX, TMAX, TMAX, TMAX, 1, 1,
                        TMAX, 2, 8, 1, 1));
        vt.push_back(mk(5, 6, 7, 8, 0, 1, TMAX, 2, 8, 1, 1));
        vt.push_back(mk(5, 6, 7, 8, 1, 0, TMAX, 2, 8, 1, 1));

        // Reset values.
        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0);
`ifdef TIME_MGR_BREAK_EN
        chk("reset.break_hit", 64'(bus.break_hit), 64'd0);
`endif

        // Directed table.
        foreach (vt[k]) begin
            ct[0] = vt[k].a; ct[1] = vt[k].b;
            ct[2] = vt[k].c; ct[3] = vt[k].d;
            bus.run  = vt[k].run;
            bus.step = vt[k].step;
            tick();
            chk_all($sformatf("vec%0d", k), vt[k].tn, vt[k].st,
                    vt[k].cnt, vt[k].sat, vt[k].mono);
        end

        // Async reset in the middle of RUN.
        do_reset();
        ct[0] = 7; ct[1] = 9; ct[2] = 11; ct[3] = 13;
        bus.run = 1'b1;
        repeat (3) tick();
        chk_all("prerst", 7, 1, 2, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("midrst", 0, 0, 0, 0, 0);
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

`ifdef TIME_MGR_BREAK_EN
        // Breakpoint stop, resume past it, and re-arm.
        do_reset();
        bus.break_time = 100;
        ct[0] = 90; ct[1] = 95; ct[2] = 120; ct[3] = 130;
        bus.run = 1'b1;
        tick();
        tick();
        chk_all("brk.pre", 90, 1, 1, 0, 0);
        ct[0] = 110; ct[1] = 115;
        tick();
        chk_all("brk.stop", 90, 2, 1, 0, 0);
        chk("brk.stop.hit", 64'(bus.break_hit), 64'd1);
        bus.run = 1'b0;
        tick();
        chk_all("brk.hold", 90, 2, 1, 0, 0);
        bus.run = 1'b1;
        tick();
        chk_all("brk.resume", 90, 1, 1, 0, 0);
        chk("brk.resume.hit", 64'(bus.break_hit), 64'd0);
        tick();
        chk_all("brk.pass", 110, 1, 2, 0, 0);
        tick();
        chk_all("brk.again", 110, 2, 2, 0, 0);
        chk("brk.again.hit", 64'(bus.break_hit), 64'd1);
`endif

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
`ifdef TIME_MGR_BREAK_EN
            bus.break_time = $urandom_range(300, 3000);
`endif
            for (int c = 0; c < 300; c++) begin
                for (int i = 0; i < N; i++) begin
                    int r;
                    r = $urandom_range(0, 199);
                    if (r < 2)      ct[i] = TMAX;
                    else if (r < 8) ct[i] = $urandom_range(0, 500);
                    else ct[i] = m_tn + $urandom_range(0, 40);
                end
                if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
                bus.step = ($urandom_range(0, 4) == 0);
                tick();
                chk_all($sformatf("rnd%0d.%0d", ep, c), m_tn, m_st,
                        m_cnt, m_sat, m_mono);
`ifdef TIME_MGR_BREAK_EN
                chk($sformatf("rnd%0d.%0d.hit", ep, c),
                    64'(bus.break_hit), 64'(m_bh));
`endif
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/time_manager.md
Name: time_manager

Overview:
- Emulation time-base arbiter for the constant and variable emulated clocks.
- Each clock publishes its next scheduled edge time on time_clock. This block reduces all of them to the global minimum and broadcasts it as time_next.
- Clocks whose time_clock equals time_next fire on that clk_sys edge and then reschedule.
- A run/halt/step FSM gates advancement of emulated time.

Parameters:
- N_CLOCKS, 4, number of emulated clocks feeding the minimum.
- TIME_WIDTH, 32, width of the emulated time words; must match the clocks' TIME_WIDTH.
- CNT_WIDTH, 32, width of the advance counter.

Ports:
- clk_sys  input  1  system (emulator) clock.
- rst_n  input  1  asynchronous active-low reset.
- time_clock_flat  input  N_CLOCKS*TIME_WIDTH  concatenated clock schedules; clock i occupies bits [i*TIME_WIDTH +: TIME_WIDTH].
- run  input  1  level request to advance emulated time freely.
- step  input  1  single-cycle pulse; performs one advance while halted.
- time_next  output  TIME_WIDTH  registered global minimum broadcast to all clocks.
- state  output  2  FSM state encoding (package enum).
- adv_count  output  CNT_WIDTH  number of time_next loads since reset; wraps modulo 2^CNT_WIDTH.
- time_sat  output  1  sticky flag: minimum reached all-ones.
- err_mono  output  1  sticky flag: computed minimum fell below time_next.

Behaviour:
- Reset (async, rst_n low) values:
  - time_next = 0, state = IDLE, adv_count = 0.
  - time_sat = 0, err_mono = 0.
  - break_hit = 0 (when the optional feature is compiled in).
- min_c = combinational minimum of all N_CLOCKS inputs, unsigned compare, evaluated each cycle.
- "Advance" means time_next <= min_c and adv_count <= adv_count+1, registered on clk_sys. No other path modifies time_next.
- FSM states:
  - IDLE: no advance. Go to RUN when run=1.
  - RUN: advance every cycle. Go to HALT when run=0, or min_c==all-ones, or break condition. The transition and the advance-suppression decision are made in the same cycle.
  - HALT: no advance, except one advance in a cycle where step=1. Go to RUN when run=1 and time_sat=0. step and run both high in HALT: the step advance occurs and the state goes to RUN.
- Saturation:
  - min_c==all-ones in RUN or on a step: time_next is loaded with all-ones, time_sat sets, state goes to HALT.
  - While time_sat=1: HALT is terminal, step is ignored. Cleared only by reset.
- Monotonicity: on any advance where min_c < time_next, err_mono sets. The advance still happens.
- Throughput: clocks compare against registered time_next.
  - Firing clocks reschedule on the same edge that reloads time_next with the pre-fire minimum.
  - Result: one emulated event every 2 clk_sys cycles. This is required behaviour, not a bug.
- Holding: in IDLE and HALT, time_next is held. A clock already equal to the held value fires at most once.
- step in IDLE or RUN is ignored.
- Reset asserted mid-RUN returns all outputs to reset values immediately.

Optional Feature:
- Macro TIME_MGR_BREAK_EN.
- Defined:
  - Adds input break_time [TIME_WIDTH] and output break_hit [1], sticky.
  - In RUN, if min_c > break_time: no advance, state goes to HALT, break_hit sets.
  - break_hit clears on the cycle HALT goes to RUN.
  - Steps bypass the breakpoint.
- Undefined: ports absent, no breakpoint logic.

Decomposition:
- Package time_mgr_pkg:
  - state_t enum: IDLE=0, RUN=1, HALT=2.
  - Default TIME_WIDTH constant.
- Sub-module min_tree (params N, W): pure combinational balanced binary reduction returning the minimum. time_manager instantiates it once.

Test Plan:
- Reset, run=1, inputs {10,25,40,60}: time_next 0 -> 10 on the first RUN edge; adv_count=1; state=RUN.
- run=1 with inputs changing {10,…} -> {30,25,40,60}: time_next becomes 25 one edge after the change.
- run dropped at time_next=25, inputs become {30,35,40,60}, then step pulsed twice:
  - time_next holds 25 while halted.
  - Goes 30 after the first step; the second step loads the then-current minimum.
  - state stays HALT.
- Input set to all-ones (0xFFFFFFFF) while running: time_next=0xFFFFFFFF, time_sat=1, HALT.
  - Further run and step: no change until rst_n.
- Inputs drop from min 50 to 20 while running: err_mono=1 and time_next=20.
- With TIME_MGR_BREAK_EN, break_time=100, inputs advancing 90 then 110:
  - time_next stops at 90, break_hit=1, HALT.
  - run toggled 0 then 1: break_hit clears and time_next=110.
